// File: rtl/bpsk_phase_gen_if.sv
// Symbol-in / phase-out bus for bpsk_phase_gen: symbol handshake, modulation settings and phase stream.
// The master side drives symbols and settings, and the slave side (the generator) returns ready/phase/underrun.
interface bpsk_phase_gen_if #(
  parameter int PHASE_W = 9,
  parameter int ACC_W   = 24,
  parameter int SPS_W   = 8
);
  logic               enable;
  logic [ACC_W-1:0]   fcw;
  logic [SPS_W-1:0]   sps;
  logic               sym_valid;
  logic               sym_bit;
  logic               sym_ready;
  logic [PHASE_W-1:0] phase_out;
  logic               phase_valid;
  logic               underrun;

  modport master (
    output enable, fcw, sps, sym_valid, sym_bit,
    input  sym_ready, phase_out, phase_valid, underrun
  );

  modport slave (
    input  enable, fcw, sps, sym_valid, sym_bit,
    output sym_ready, phase_out, phase_valid, underrun
  );
endinterface

// File: rtl/bpsk_phase_gen.sv
// BPSK phase generator: phase-continuous NCO whose top bits are offset by a half turn for '1' symbols.
// Optional macro BPSK_DIFF_EN selects differential encoding (flip = sym_bit XOR previous flip).
module bpsk_phase_gen #(
  parameter int PHASE_W = 9,
  parameter int ACC_W   = 24,
  parameter int SPS_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  bpsk_phase_gen_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   fcw_q, fcw_d;
  logic [SPS_W-1:0]   rem_q, rem_d;
  logic               flip_q, flip_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               underrun_q, underrun_d;

  logic               accept;
  logic               lastSample;
  logic [SPS_W-1:0]   spsEff;
  logic [PHASE_W-1:0] phaseRun;

  assign lastSample = (rem_q == SPS_W'(1));
  assign spsEff     = (bus.sps == '0) ? SPS_W'(1) : bus.sps;
  assign phaseRun   = acc_q[ACC_W-1 -: PHASE_W] + {flip_q, {(PHASE_W-1){1'b0}}};

  // Ready is gated by rst_n so it reads 0 during reset even while enable is high.
  assign bus.sym_ready   = rst_n & bus.enable & ((state_q == IDLE) | lastSample);
  assign accept          = bus.sym_valid & bus.sym_ready;
  assign bus.phase_valid = (state_q == RUN);
  assign bus.phase_out   = (state_q == RUN) ? phaseRun : phase_q;
  assign bus.underrun    = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      fcw_q      <= '0;
      rem_q      <= '0;
      flip_q     <= 1'b0;
      phase_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fcw_q      <= fcw_d;
      rem_q      <= rem_d;
      flip_q     <= flip_d;
      phase_q    <= phase_d;
      underrun_q <= underrun_d;
    end
  end

  // The accumulator advances on every RUN cycle, including the one that accepts the next symbol,
  // which keeps the carrier phase-continuous across symbols.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    fcw_d      = fcw_q;
    rem_d      = rem_q;
    flip_d     = flip_q;
    phase_d    = phase_q;
    underrun_d = 1'b0;

    if (state_q == RUN) begin
      acc_d   = acc_q + fcw_q;
      rem_d   = rem_q - SPS_W'(1);
      phase_d = phaseRun;
      if (lastSample && !accept) begin
        state_d    = IDLE;
        underrun_d = 1'b1;
      end
    end

    if (accept) begin
      state_d = RUN;
      fcw_d   = bus.fcw;
      rem_d   = spsEff;
`ifdef BPSK_DIFF_EN
      flip_d  = bus.sym_bit ^ flip_q;
`else
      flip_d  = bus.sym_bit;
`endif
    end
  end

endmodule

// File: tb/tb_bpsk_phase_gen.sv
// Directed, table-driven bench for bpsk_phase_gen; expected phases are hand-computed from
// acc[23:15] + 256*flip. Stimulus is driven on the falling edge and outputs are checked 1 ns later.
module tb_bpsk_phase_gen;

  localparam logic [23:0] F15 = 24'h008000;
  localparam logic [23:0] F23 = 24'h800000;
`ifdef BPSK_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  typedef struct {
    string       name;
    bit          rst;
    bit          en;
    bit          v;
    bit          b;
    logic [23:0] f;
    logic [7:0]  s;
    bit          eV;
    logic [8:0]  eP;
    bit          eU;
    bit          eR;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  bpsk_phase_gen_if #(.PHASE_W(9), .ACC_W(24), .SPS_W(8)) bus ();

  bpsk_phase_gen #(.PHASE_W(9), .ACC_W(24), .SPS_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(string name, bit rst, bit en, bit v, bit b, logic [23:0] f,
                                 logic [7:0] s, bit eV, logic [8:0] eP, bit eU, bit eR);
    vec_t t;
    t.name = name; t.rst = rst; t.en = en; t.v = v; t.b = b; t.f = f; t.s = s;
    t.eV = eV; t.eP = eP; t.eU = eU; t.eR = eR;
    vecs.push_back(t);
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst_n         = ~t.rst;
    bus.enable    = t.en;
    bus.sym_valid = t.v;
    bus.sym_bit   = t.b;
    bus.fcw       = t.f;
    bus.sps       = t.s;
  endtask

  task automatic checkOutput(input string name, input bit eV, input logic [8:0] eP,
                             input bit eU, input bit eR);
    checks += 4;
    if (bus.phase_valid !== eV) begin
      errors++;
      $display("[TB] FAIL %s phase_valid got %b want %b", name, bus.phase_valid, eV);
    end
    if (bus.phase_out !== eP) begin
      errors++;
      $display("[TB] FAIL %s phase_out got %0d want %0d", name, bus.phase_out, eP);
    end
    if (bus.underrun !== eU) begin
      errors++;
      $display("[TB] FAIL %s underrun got %b want %b", name, bus.underrun, eU);
    end
    if (bus.sym_ready !== eR) begin
      errors++;
      $display("[TB] FAIL %s sym_ready got %b want %b", name, bus.sym_ready, eR);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.sym_valid = 1'b0; bus.sym_bit = 1'b0;
    bus.fcw = '0; bus.sps = '0;

    //     name     rst en v  b  fcw  sps  eV eP   eU eR
    addVec("a_rst", 1, 1, 0, 0, F15, 4,   0, 0,   0, 0);
    addVec("a_acc", 0, 1, 1, 0, F15, 4,   0, 0,   0, 1);
    addVec("a_s0",  0, 1, 0, 0, F15, 4,   1, 0,   0, 0);
    addVec("a_s1",  0, 1, 0, 0, F15, 4,   1, 1,   0, 0);
    addVec("a_s2",  0, 1, 0, 0, F15, 4,   1, 2,   0, 0);
    addVec("a_s3",  0, 1, 0, 0, F15, 4,   1, 3,   0, 1);
    addVec("a_und", 0, 1, 0, 0, F15, 4,   0, 3,   1, 1);
    addVec("a_idl", 0, 1, 0, 0, F15, 4,   0, 3,   0, 1);

    addVec("b_rst", 1, 1, 0, 0, F15, 4,   0, 0,   0, 0);
    addVec("b_acc", 0, 1, 1, 1, F15, 4,   0, 0,   0, 1);
    addVec("b_s0",  0, 1, 0, 0, F15, 4,   1, 256, 0, 0);
    addVec("b_s1",  0, 1, 0, 0, F15, 4,   1, 257, 0, 0);
    addVec("b_s2",  0, 1, 0, 0, F15, 4,   1, 258, 0, 0);
    addVec("b_s3",  0, 1, 0, 0, F15, 4,   1, 259, 0, 1);
    addVec("b_und", 0, 1, 0, 0, F15, 4,   0, 259, 1, 1);

    addVec("c_rst", 1, 1, 0, 0, F15, 2,   0, 0,   0, 0);
    addVec("c_acc", 0, 1, 1, 0, F15, 2,   0, 0,   0, 1);
    addVec("c_s0",  0, 1, 1, 1, F15, 2,   1, 0,   0, 0);
    addVec("c_s1",  0, 1, 1, 1, F15, 2,   1, 1,   0, 1);
    addVec("c_s2",  0, 1, 1, 0, F15, 2,   1, 258, 0, 0);
    addVec("c_s3",  0, 1, 1, 0, F15, 2,   1, 259, 0, 1);
    addVec("c_s4",  0, 1, 0, 0, F15, 2,   1, DIFF ? 9'd260 : 9'd4, 0, 0);
    addVec("c_s5",  0, 1, 0, 0, F15, 2,   1, DIFF ? 9'd261 : 9'd5, 0, 1);
    addVec("c_und", 0, 1, 0, 0, F15, 2,   0, DIFF ? 9'd261 : 9'd5, 1, 1);

    addVec("d_rst", 1, 1, 0, 0, F23, 3,   0, 0,   0, 0);
    addVec("d_acc", 0, 1, 1, 0, F23, 3,   0, 0,   0, 1);
    addVec("d_s0",  0, 1, 0, 0, F23, 3,   1, 0,   0, 0);
    addVec("d_s1",  0, 1, 0, 0, F23, 3,   1, 256, 0, 0);
    addVec("d_s2",  0, 1, 0, 0, F23, 3,   1, 0,   0, 1);
    addVec("d_und", 0, 1, 0, 0, F23, 3,   0, 0,   1, 1);

    addVec("e_rst", 1, 1, 0, 0, F15, 0,   0, 0,   0, 0);
    addVec("e_acc", 0, 1, 1, 0, F15, 0,   0, 0,   0, 1);
    addVec("e_s0",  0, 1, 1, 0, F15, 0,   1, 0,   0, 1);
    addVec("e_s1",  0, 1, 0, 0, F15, 0,   1, 1,   0, 1);
    addVec("e_und", 0, 1, 0, 0, F15, 0,   0, 1,   1, 1);

    // Enable drops mid-symbol and fcw/sps change in flight: symbol still finishes unchanged.
    addVec("f_rst", 1, 1, 0, 0, F15, 2,   0, 0,   0, 0);
    addVec("f_acc", 0, 1, 1, 0, F15, 2,   0, 0,   0, 1);
    addVec("f_s0",  0, 0, 1, 0, F23, 5,   1, 0,   0, 0);
    addVec("f_s1",  0, 0, 1, 0, F23, 5,   1, 1,   0, 0);
    addVec("f_und", 0, 0, 1, 0, F23, 5,   0, 1,   1, 0);

    addVec("g_rst", 1, 1, 0, 0, 0,   1,   0, 0,   0, 0);
    addVec("g_acc", 0, 1, 1, 1, 0,   1,   0, 0,   0, 1);
    addVec("g_s0",  0, 1, 1, 1, 0,   1,   1, 256, 0, 1);
    addVec("g_s1",  0, 1, 1, 0, 0,   1,   1, DIFF ? 9'd0 : 9'd256, 0, 1);
    addVec("g_s2",  0, 1, 0, 0, 0,   1,   1, 0,   0, 1);
    addVec("g_und", 0, 1, 0, 0, 0,   1,   0, 0,   1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i].name, vecs[i].eV, vecs[i].eP, vecs[i].eU, vecs[i].eR);
    end

    // Reset asserted mid-symbol while clk is high: outputs clear without waiting for an edge.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable = 1'b1; bus.sym_valid = 1'b1; bus.sym_bit = 1'b1; bus.fcw = F15; bus.sps = 8'd4;
    @(negedge clk);
    bus.sym_valid = 1'b0;
    #1 checkOutput("r_s0", 1, 256, 0, 0);
    @(negedge clk);
    #1 checkOutput("r_s1", 1, 257, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("r_async", 0, 0, 0, 0);
    @(negedge clk);
    #1 checkOutput("r_held", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.sym_valid = 1'b1; bus.sym_bit = 1'b0; bus.sps = 8'd2;
    #1 checkOutput("r_rel", 0, 0, 0, 1);
    @(negedge clk);
    bus.sym_valid = 1'b0;
    #1 checkOutput("r_n0", 1, 0, 0, 0);
    @(negedge clk);
    #1 checkOutput("r_n1", 1, 1, 0, 1);
    @(negedge clk);
    #1 checkOutput("r_und", 0, 1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpsk_phase_gen.md
BPSK_PHASE_GEN -- requirements
Module: bpsk_phase_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 9: width of the phase index, matching the cosine_lut input.
REQ-002 SHALL have parameter ACC_W, default 24: width of the phase accumulator, ACC_W > PHASE_W.
REQ-003 SHALL have parameter SPS_W, default 8: width of the samples-per-symbol field.
REQ-004 SHALL have port clk, input, 1: the single clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1: allows new symbols to be accepted.
REQ-007 SHALL have port fcw, input, ACC_W: frequency control word, sampled on symbol accept.
REQ-008 SHALL have port sps, input, SPS_W: samples per symbol, sampled on accept; 0 is treated as 1.
REQ-009 SHALL have port sym_valid, input, 1: a symbol is offered.
REQ-010 SHALL have port sym_bit, input, 1: the symbol value; 1 means a pi phase flip.
REQ-011 SHALL have port sym_ready, output, 1: the block accepts a symbol this cycle.
REQ-012 SHALL have port phase_out, output, PHASE_W: phase index that drives a cosine_lut read port.
REQ-013 SHALL have port phase_valid, output, 1: phase_out carries a valid sample.
REQ-014 SHALL have port underrun, output, 1: one-cycle pulse when a symbol ends with no successor.

Function
REQ-015 SHALL implement two states: IDLE and RUN.
REQ-016 Accept SHALL occur on a rising edge with sym_valid & sym_ready both high.
REQ-017 In IDLE, sym_ready SHALL equal enable.
REQ-018 In RUN, sym_ready SHALL equal enable & (remaining == 1), where remaining counts the current symbol's samples left including the present one.
REQ-019 On accept the block SHALL latch the flip bit, fcw and max(sps,1), set remaining to max(sps,1), and enter or stay in RUN.
REQ-020 In RUN, phase_out SHALL equal acc[ACC_W-1 -: PHASE_W] + flip*2^(PHASE_W-1), modulo 2^PHASE_W.
REQ-021 In RUN, phase_valid SHALL be 1, and every clock SHALL perform acc <= acc + fcw_latched (wrapping modulo 2^ACC_W) and remaining <= remaining - 1.
REQ-022 Latency SHALL be: accept at edge N gives phase_valid high from cycle N+1 for exactly max(sps,1) consecutive cycles.
REQ-023 Back-to-back symbols SHALL produce no gap in phase_valid, and the accumulator SHALL stay phase-continuous across symbols and fcw changes.
REQ-024 On the edge where remaining == 1 with no accept, the block SHALL go to IDLE and pulse underrun for one cycle.
REQ-025 In IDLE, phase_valid SHALL be 0, phase_out SHALL hold its last value, and acc SHALL not advance.
REQ-026 enable falling in RUN SHALL not abort the current symbol; it SHALL only block the next accept.
REQ-027 fcw or sps changes between accepts SHALL have no effect on the symbol in flight.

Reset
REQ-028 While rst_n = 0, the block SHALL force state = IDLE, acc = 0, remaining = 0, flip = 0, phase_out = 0, phase_valid = 0, sym_ready = 0 and underrun = 0, regardless of clk.
REQ-029 Reset asserted mid-symbol SHALL discard the symbol; after release the first sample SHALL start at phase 0.

Configuration
REQ-030 The BPSK_DIFF_EN macro, when defined, SHALL select differential encoding: flip <= sym_bit XOR previous flip on each accept, with previous flip reset to 0.
REQ-031 When BPSK_DIFF_EN is undefined, flip SHALL equal sym_bit, and no differential state register SHALL exist.

Verification
REQ-032 Bench SHALL cover: fcw = 2^15, sps = 4, one symbol with bit 0 -> phase_out 0, 1, 2, 3 with phase_valid high for 4 cycles, then an underrun pulse.
REQ-033 Bench SHALL cover: same settings, bit 1 -> phase_out 256, 257, 258, 259.
REQ-034 Bench SHALL cover: sym_valid held high with bits 0, 1, 0 and sps = 2 -> 6 contiguous valid cycles with phase_out 0, 1, 258, 259, 4, 5 and no underrun until the end.
REQ-035 Bench SHALL cover: fcw = 2^23 (half turn per sample), sps = 3 -> phase_out 0, 256, 0, showing accumulator wrap.
REQ-036 Bench SHALL cover: sps = 0 -> exactly one valid sample per symbol.
REQ-037 Bench SHALL cover: with BPSK_DIFF_EN defined, bits 1, 1, 0 -> flips 1, 0, 0; also rst_n pulsed low mid-symbol -> phase_valid drops immediately and the next symbol starts at phase_out 0.
